// File: rtl/if_fill_ctrl.sv
// if_fill_ctrl: streams one row of words into the IF scratch ring buffer.
// It tracks how many entries are resident, flags when a full filter window is
// present, and pulses done once the consumer has released every word of the row.
module if_fill_ctrl #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 32,
  parameter int LEN_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         total_len,
  input  logic [ADDR_LEN:0]        win_len,
  input  logic                     in_valid,
  input  logic [SCRATCH_WIDTH-1:0] in_data,
  output logic                     in_ready,
  input  logic                     rel,
  output logic                     sc_wen,
  output logic [ADDR_LEN-1:0]      sc_waddr,
  output logic [SCRATCH_WIDTH-1:0] sc_din,
  output logic [ADDR_LEN-1:0]      rd_base,
  output logic [ADDR_LEN:0]        count,
  output logic                     win_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_LEN:0]   DEPTH_C = (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_LEN-1:0] LAST_C  = ADDR_LEN'(SCRATCH_DEPTH - 1);
  localparam logic [ADDR_LEN:0]   ONE_C   = (ADDR_LEN+1)'(1);

  state_t              state, state_nxt;
  logic [ADDR_LEN-1:0] wptr, rptr;
  logic [ADDR_LEN:0]   cnt;
  logic [LEN_W-1:0]    received, tot_len;
  logic [ADDR_LEN:0]   win_q;

  logic                active;
  logic                xfer;
  logic                rel_ok;
  logic [LEN_W-1:0]    received_inc;
  logic [ADDR_LEN:0]   win_min;

  // Datapath decode: the handshake depends only on registered state, so
  // in_ready has no combinational path from in_valid or rel.
  assign active       = (state == S_FILL) || (state == S_DRAIN);
  assign in_ready     = (state == S_FILL) && (cnt < DEPTH_C);
  assign xfer         = in_valid && in_ready;
  assign rel_ok       = rel && active && (cnt != '0);
  assign received_inc = received + 1'b1;
  assign win_min      = (win_q == '0) ? ONE_C : win_q;

  assign sc_wen    = xfer;
  assign sc_waddr  = wptr;
  assign sc_din    = xfer ? in_data : '0;
  assign rd_base   = rptr;
  assign count     = cnt;
  assign win_ready = active && (cnt >= win_min);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Next-state logic for the row sequencer.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (total_len == '0) ? S_DONE : S_FILL;
      S_FILL:  if (xfer && (received_inc == tot_len)) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus ring-buffer pointers, occupancy and row bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      received <= '0;
      tot_len  <= '0;
      win_q    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        tot_len  <= total_len;
        win_q    <= win_len;
        wptr     <= '0;
        rptr     <= '0;
        cnt      <= '0;
        received <= '0;
      end else begin
        if (xfer) begin
          wptr     <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
          received <= received_inc;
        end
        if (rel_ok) begin
          rptr <= (rptr == LAST_C) ? '0 : rptr + 1'b1;
        end
        // Simultaneous write and release leave occupancy unchanged.
        unique case ({xfer, rel_ok})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule
